m_mem_arbiter: RTL

M_MEM_ARBITER -- requirements
Module: m_mem_arbiter

---
 rtl/m_mem_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/m_mem_arbiter.sv
// rtl/m_mem_arbiter.sv - two-port round-robin arbiter for a single-port registered memory
module m_mem_arbiter #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          w_clk,
   input  logic          w_rst_n,
   input  logic          w_halt,
   input  logic          w_req0,
   input  logic          w_req1,
   input  logic          w_we0,
   input  logic          w_we1,
   input  logic [AW-1:0] w_addr0,
   input  logic [AW-1:0] w_addr1,
   input  logic [DW-1:0] w_wdata0,
   input  logic [DW-1:0] w_wdata1,
   output logic          r_gnt0,
   output logic          r_gnt1,
   output logic          r_rvalid0,
   output logic          r_rvalid1,
   output logic [DW-1:0] w_rdata,
   output logic [AW-1:0] r_maddr,
   output logic          r_mwe,
   output logic [DW-1:0] r_mdin,
   input  logic [DW-1:0] w_mdout,
   output logic          r_busy,
   output logic [31:0]   r_nacc
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} t_state;

   t_state r_state;
   t_state w_next;
   logic   r_sel;
   logic   r_last;
   logic   r_we;
   logic   w_any;
   logic   w_win;
   logic   w_take;

   // Tie goes to the port that did not win last; r_last resets to 1 so port 0 wins first.
   always_comb begin
      w_any  = (w_req0 | w_req1) & ~w_halt;
      w_win  = (w_req0 & w_req1) ? ~r_last : w_req1;
      w_next = r_state;
      w_take = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_next = ST_ISSUE;
               w_take = 1'b1;
            end
         end
         ST_ISSUE: w_next = ST_RESP;
         ST_RESP: begin
            if (w_any) begin
               w_next = ST_ISSUE;
               w_take = 1'b1;
            end else begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= ST_IDLE;
         r_maddr <= '0;
         r_mdin  <= '0;
         r_we    <= 1'b0;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
         r_nacc  <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_maddr <= w_win ? w_addr1 : w_addr0;
            r_mdin  <= w_win ? w_wdata1 : w_wdata0;
            r_we    <= w_win ? w_we1 : w_we0;
            r_sel   <= w_win;
            r_last  <= w_win;
         end
         if (r_state == ST_RESP) begin
            r_nacc <= r_nacc + 32'd1;
         end
      end
   end

   // Decoded from the async-reset state so a reset mid-ISSUE drops the write strobe at once.
   always_comb begin
      r_gnt0    = (r_state == ST_ISSUE) & ~r_sel;
      r_gnt1    = (r_state == ST_ISSUE) &  r_sel;
      r_rvalid0 = (r_state == ST_RESP)  & ~r_sel;
      r_rvalid1 = (r_state == ST_RESP)  &  r_sel;
      r_mwe     = (r_state == ST_ISSUE) &  r_we;
      r_busy    = (r_state != ST_IDLE);
      w_rdata   = (r_state == ST_RESP) ? w_mdout : '0;
   end

endmodule
